// File: rtl/dot_product_mac.sv
// Multi-lane signed multiply-accumulate engine.
// Each accepted beat carries LANES operand pairs; their dot product is summed
// across a burst framed by first/last tags, and one ACC_WIDTH result per burst
// is returned over a ready/valid handshake. Two pipeline stages (products, then
// adder tree) feed an accumulator that saturates or wraps on signed overflow.
module dot_product_mac #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [LANES*WIDTH-1:0] x,
    input  logic [LANES*WIDTH-1:0] y,
    output logic [ACC_WIDTH-1:0]   mac,
    output logic                   overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_e;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Sign-extend both lane operands to full product width before multiplying.
    function automatic logic signed [2*WIDTH-1:0] lane_mul(input logic [WIDTH-1:0] a,
                                                           input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] a_ext;
        logic signed [2*WIDTH-1:0] b_ext;
        a_ext = (2*WIDTH)'($signed(a));
        b_ext = (2*WIDTH)'($signed(b));
        return a_ext * b_ext;
    endfunction

    state_e                      state_q;
    logic                        out_valid_q;
    logic [ACC_WIDTH-1:0]        mac_q;
    logic                        ovf_out_q;

    logic                        p1_valid_q, p1_first_q, p1_last_q;
    logic signed [2*WIDTH-1:0]   p1_prod_d [LANES];
    logic signed [2*WIDTH-1:0]   p1_prod_q [LANES];

    logic                        p2_valid_q, p2_first_q, p2_last_q;
    logic signed [ACC_WIDTH-1:0] p2_sum_d;
    logic signed [ACC_WIDTH-1:0] p2_sum_q;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        ovf_q, ovf_d;

    logic                        accept;
    logic                        last_in_flight;
    logic                        p2_closes;

    assign accept         = in_valid && in_ready;
    assign last_in_flight = (p1_valid_q && p1_last_q) || (p2_valid_q && p2_last_q);
    assign p2_closes      = p2_valid_q && p2_last_q;

    assign in_ready  = !out_valid_q && !last_in_flight;
    assign out_valid = out_valid_q;
    assign mac       = mac_q;
    assign overflow  = ovf_out_q;
    assign busy      = (state_q != S_IDLE) || p1_valid_q || p2_valid_q;

    // Per-lane signed products of the offered beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            p1_prod_d[i] = lane_mul(x[i*WIDTH +: WIDTH], y[i*WIDTH +: WIDTH]);
        end
    end

    // P1 register: products and burst tags of the accepted beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p1_valid_q <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            // NOTE: the product array is only LANES entries wide, so it is reset
            // with everything else; a reset must leave no stale beat behind.
            for (int i = 0; i < LANES; i++) begin
                p1_prod_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            p1_valid_q <= accept;
            p1_first_q <= accept && in_first;
            p1_last_q  <= accept && in_last;
            for (int i = 0; i < LANES; i++) begin
                p1_prod_q[i] <= accept ? p1_prod_d[i] : '0;
            end
        end
    end

    // Balanced adder tree over the sign-extended products (leaves at the back).
    always_comb begin
        logic signed [ACC_WIDTH-1:0] tree [2*LANES-1];
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        for (int k = 0; k < 2*LANES-1; k++) begin
            tree[k] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            tree[LANES-1+i] = ACC_WIDTH'(p1_prod_q[i]);
        end
        for (int k = LANES-2; k >= 0; k--) begin
            tree[k] = tree[2*k+1] + tree[2*k+2];
        end
        p2_sum_d = tree[0];
    end

    // P2 register: beat sum and tags, ready to be folded into the accumulator.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p2_valid_q <= 1'b0;
            p2_first_q <= 1'b0;
            p2_last_q  <= 1'b0;
            p2_sum_q   <= '0;
        end else begin
            p2_valid_q <= p1_valid_q;
            p2_first_q <= p1_first_q;
            p2_last_q  <= p1_last_q;
            p2_sum_q   <= p2_sum_d;
        end
    end

    // Next accumulator value with signed-overflow detection and optional clamp.
    always_comb begin
        logic signed [ACC_WIDTH-1:0] base;
        logic signed [ACC_WIDTH-1:0] raw;
        logic                        ovf_now;
        base    = p2_first_q ? '0 : acc_q;
        raw     = base + p2_sum_q;
        ovf_now = (base[ACC_WIDTH-1] == p2_sum_q[ACC_WIDTH-1]) &&
                  (raw[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        acc_d   = raw;
        if (ovf_now && (SATURATE != 0)) begin
            acc_d = base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
        ovf_d = (p2_first_q ? 1'b0 : ovf_q) | ovf_now;
    end

    // Accumulator and sticky overflow; both restart at zero once a burst closes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (p2_valid_q) begin
            acc_q <= p2_last_q ? '0 : acc_d;
            ovf_q <= p2_last_q ? 1'b0 : ovf_d;
        end
    end

    // Handshake FSM with registered result, flag and out_valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            mac_q       <= '0;
            ovf_out_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (p2_closes) begin
                        state_q     <= S_HOLD;
                        out_valid_q <= 1'b1;
                        mac_q       <= acc_d;
                        ovf_out_q   <= ovf_d;
                    end else if (accept && !in_last) begin
                        state_q <= S_ACCUM;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// Bench for dot_product_mac: three instances share one stimulus stream
// (32-bit saturating, 18-bit saturating, 18-bit wrapping). A transaction-level
// model tracks burst sums with plain integer arithmetic and the handshake
// timing as simple counters; every cycle the DUT outputs are compared to it.
module tb_dot_product_mac;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] x = '0;
    logic [31:0] y = '0;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        busy0, busy1, busy2;
    logic        overflow0, overflow1, overflow2;
    logic [31:0] mac0;
    logic [17:0] mac1, mac2;

    int checks = 0;
    int errors = 0;
    bit ormode = 1'b0;

    // Model state (written only by the model process).
    bit     m_open = 0, m_pend = 0, m_ov = 0, m_h1 = 0, m_h2 = 0;
    int     m_cd = 0;
    longint m_acc [3];
    bit     m_ovf [3];
    longint m_pmac[3];
    bit     m_povf[3];
    longint m_mac [3];
    bit     m_ovfo[3];

    dot_product_mac u_dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_first(in_first), .in_last(in_last), .x(x), .y(y), .mac(mac0),
        .overflow(overflow0), .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0)
    );

    dot_product_mac #(.ACC_WIDTH(18), .SATURATE(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_first(in_first), .in_last(in_last), .x(x), .y(y), .mac(mac1),
        .overflow(overflow1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1)
    );

    dot_product_mac #(.ACC_WIDTH(18), .SATURATE(0)) u_dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_first(in_first), .in_last(in_last), .x(x), .y(y), .mac(mac2),
        .overflow(overflow2), .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2)
    );

    always #5 clock = ~clock;

    function automatic int aw(input int c);
        return (c == 0) ? 32 : 18;
    endfunction

    function automatic bit sat(input int c);
        return c != 2;
    endfunction

    function automatic longint wrap(input longint v, input int w);
        longint r;
        r = v & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic longint dot(input logic [31:0] xv, input logic [31:0] yv);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(xv[i*8 +: 8])) * longint'($signed(yv[i*8 +: 8]));
        end
        return s;
    endfunction

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic longint mac_of(input int c);
        case (c)
            0:       return longint'($signed(mac0));
            1:       return longint'($signed(mac1));
            default: return longint'($signed(mac2));
        endcase
    endfunction

    function automatic logic ready_of(input int c);
        return (c == 0) ? in_ready0 : (c == 1) ? in_ready1 : in_ready2;
    endfunction

    function automatic logic valid_of(input int c);
        return (c == 0) ? out_valid0 : (c == 1) ? out_valid1 : out_valid2;
    endfunction

    function automatic logic busy_of(input int c);
        return (c == 0) ? busy0 : (c == 1) ? busy1 : busy2;
    endfunction

    function automatic logic ovf_of(input int c);
        return (c == 0) ? overflow0 : (c == 1) ? overflow1 : overflow2;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: burst arithmetic at accept time, result appears two
    // edges after the last beat is accepted and stays until consumed.
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_open = 0; m_pend = 0; m_ov = 0; m_h1 = 0; m_h2 = 0; m_cd = 0;
                for (int c = 0; c < 3; c++) begin
                    m_acc[c] = 0;
                    m_ovf[c] = 0;
                end
            end else begin
                bit     take;
                longint s;
                take = in_valid && !m_pend && !m_ov;
                if (m_ov && out_ready) begin
                    m_ov = 0;
                    m_pend = 0;
                end
                m_h2 = m_h1;
                m_h1 = take;
                if (m_cd > 0) begin
                    m_cd--;
                    if (m_cd == 0) begin
                        m_ov = 1;
                        for (int c = 0; c < 3; c++) begin
                            m_mac[c]  = m_pmac[c];
                            m_ovfo[c] = m_povf[c];
                        end
                    end
                end
                if (take) begin
                    s = dot(x, y);
                    for (int c = 0; c < 3; c++) begin
                        longint base, raw, mx, mn;
                        mx = (longint'(1) << (aw(c) - 1)) - 1;
                        mn = -mx - 1;
                        if (in_first) m_ovf[c] = 0;
                        base = in_first ? 0 : m_acc[c];
                        raw = base + s;
                        if (raw > mx || raw < mn) begin
                            m_ovf[c] = 1;
                            raw = sat(c) ? ((raw > mx) ? mx : mn) : wrap(raw, aw(c));
                        end
                        if (in_last) begin
                            m_pmac[c] = raw;
                            m_povf[c] = m_ovf[c];
                            m_acc[c] = 0;
                            m_ovf[c] = 0;
                        end else begin
                            m_acc[c] = raw;
                        end
                    end
                    m_open = !in_last;
                    if (in_last) begin
                        m_pend = 1;
                        m_cd = 2;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    task automatic compare_all();
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("cfg%0d in_ready", c), ready_of(c), !(m_pend || m_ov));
                check($sformatf("cfg%0d out_valid", c), valid_of(c), m_ov);
                check($sformatf("cfg%0d busy", c), busy_of(c),
                      m_open || m_pend || m_h1 || m_h2 || m_ov);
                if (m_ov) begin
                    check($sformatf("cfg%0d mac", c), mac_of(c), m_mac[c]);
                    check($sformatf("cfg%0d overflow", c), ovf_of(c), m_ovfo[c]);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        compare_all();
        if (ormode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input bit f, input bit l, input logic [31:0] xv,
                             input logic [31:0] yv, output int waits);
        logic rdy;
        in_valid = 1'b1; in_first = f; in_last = l; x = xv; y = yv;
        waits = 0;
        forever begin
            rdy = in_ready0;
            tick();
            if (rdy) break;
            waits++;
            if (waits >= 300) begin
                check("send_beat timeout", waits, 0);
                break;
            end
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!out_valid0 && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid0) check("wait out_valid timeout", n, -1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w, n;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset mac", mac0, 0);
        check("reset overflow", overflow0, 0);
        check("reset in_ready", in_ready0, 1);
        check("reset busy", busy0, 0);

        // Single-beat burst.
        send_beat(1, 1, pack(1, 2, 3, 4), pack(5, 6, 7, 8), w);
        wait_ov(n);
        check("single latency", n, 2);
        check("single mac", mac0, 70);
        check("single model mac", m_mac[0], 70);
        check("single overflow", overflow0, 0);

        // Three back-to-back signed beats.
        for (int b = 0; b < 3; b++) begin
            send_beat(b == 0, b == 2, pack(-3, -3, -3, -3), pack(2, 2, 2, 2), w);
            if (b > 0) check($sformatf("burst3 beat%0d waits", b), w, 0);
        end
        wait_ov(n);
        check("burst3 mac", mac_of(0), -72);
        check("burst3 model mac", m_mac[0], -72);
        tick();

        // Backpressure: result held stable, input blocked, then released.
        out_ready = 1'b0;
        send_beat(1, 1, pack(10, -20, 30, -40), pack(1, 1, 1, 1), w);
        wait_ov(n);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp mac stable", mac_of(0), -20);
            check("bp in_ready", in_ready0, 0);
            check("bp out_valid", out_valid0, 1);
        end
        out_ready = 1'b1;
        send_beat(1, 1, pack(1, 2, 3, 4), pack(1, 1, 1, 1), w);
        check("bp accept delay", w, 1);
        wait_ov(n);
        check("bp next mac", mac0, 10);
        tick();

        // Overflow: 20 beats of 127*127 per lane.
        for (int b = 0; b < 20; b++) begin
            send_beat(b == 0, b == 19, pack(127, 127, 127, 127), pack(127, 127, 127, 127), w);
        end
        wait_ov(n);
        check("ovf cfg0 mac", mac0, 1290320);
        check("ovf cfg0 flag", overflow0, 0);
        check("ovf sat mac", mac_of(1), 131071);
        check("ovf sat flag", overflow1, 1);
        check("ovf wrap mac", mac_of(2), -20400);
        check("ovf wrap flag", overflow2, 1);
        tick();
        send_beat(1, 1, pack(1, 2, 3, 4), pack(5, 6, 7, 8), w);
        wait_ov(n);
        check("post ovf flag sat", overflow1, 0);
        check("post ovf flag wrap", overflow2, 0);
        check("post ovf mac wrap", mac_of(2), 70);
        tick();

        // Re-first mid-burst discards the partial sum.
        send_beat(1, 0, pack(50, 60, 70, 80), pack(9, 9, 9, 9), w);
        send_beat(0, 0, pack(-5, 7, 11, 13), pack(3, 3, 3, 3), w);
        send_beat(1, 0, pack(1, 1, 1, 1), pack(1, 2, 3, 4), w);
        send_beat(0, 1, pack(2, 0, 0, 0), pack(3, 0, 0, 0), w);
        wait_ov(n);
        check("refirst mac cfg0", mac_of(0), 16);
        check("refirst mac cfg1", mac_of(1), 16);
        check("refirst mac cfg2", mac_of(2), 16);
        tick();

        // Reset mid-burst.
        send_beat(1, 0, pack(100, 100, 100, 100), pack(100, 100, 100, 100), w);
        send_beat(0, 0, pack(100, 100, 100, 100), pack(100, 100, 100, 100), w);
        reset = 1'b0;
        #1;
        check("rst mid out_valid", out_valid0, 0);
        check("rst mid busy", busy0, 0);
        tick();
        reset = 1'b1;
        send_beat(0, 1, pack(1, 2, 3, 4), pack(5, 6, 7, 8), w);
        wait_ov(n);
        check("rst mid next mac", mac0, 70);
        tick();

        // Reset while holding a result.
        out_ready = 1'b0;
        send_beat(1, 1, pack(-100, 90, -80, 70), pack(5, 5, 5, 5), w);
        wait_ov(n);
        reset = 1'b0;
        #1;
        check("rst hold out_valid", out_valid0, 0);
        check("rst hold busy", busy0, 0);
        check("rst hold mac", mac0, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        send_beat(0, 1, pack(1, 2, 3, 4), pack(5, 6, 7, 8), w);
        wait_ov(n);
        check("rst hold next mac", mac0, 70);
        tick();

        // Randomised bursts with random gaps and consumer stalls.
        ormode = 1'b1;
        for (int k = 0; k < 60; k++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                bit f;
                f = (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
                send_beat(f, b == len - 1, $urandom, $urandom, w);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            end
        end
        ormode = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
